// File: rtl/mbox_arb_pkg.sv
// rtl/mbox_arb_pkg.sv - shared state encoding and byte count for the mailbox write arbiter
package mbox_arb_pkg;

    typedef enum logic {
        MBOX_ARB_IDLE  = 1'b0,
        MBOX_ARB_SHIFT = 1'b1
    } mbox_arb_state_t;

    localparam int MBOX_BYTES = 4;

endpackage

// File: rtl/mbox_wr_arbiter_rr_pick.sv
// rtl/mbox_wr_arbiter_rr_pick.sv - combinational round-robin priority encoder
// Searches i_ptr+1 .. i_ptr+NREQ (mod NREQ) and returns the first asserted request.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_onehot,
    output logic [IW-1:0]   o_idx,
    output logic            o_valid
);

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!o_valid && i_req[(int'(i_ptr) + i) % NREQ]) begin
                o_valid  = 1'b1;
                o_idx    = IW'((int'(i_ptr) + i) % NREQ);
                o_onehot = NREQ'(1) << ((int'(i_ptr) + i) % NREQ);
            end
        end
    end

endmodule

// File: rtl/mbox_wr_arbiter.sv
// rtl/mbox_wr_arbiter.sv - round-robin arbiter serializing 32-bit requester words into the mailbox byte port
// A lock held through a word's ack keeps the grant for that requester's next word.
module mbox_wr_arbiter
    import mbox_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int WB_DW  = 32,
    parameter int WOU_DW = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ-1:0]       lock_i,
    input  logic [NREQ*WB_DW-1:0] dat_i,
    output logic [NREQ-1:0]       ack_o,
    output logic [NREQ-1:0]       grant_o,
    output logic                  busy_o,
    output logic                  mbox_wr_o,
    output logic [WOU_DW-1:0]     mbox_do_o,
    input  logic                  mbox_full_i
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MBOX_BYTES);
    localparam logic [CW-1:0] LAST_CNT = CW'(MBOX_BYTES - 1);

    mbox_arb_state_t  r_state;
    mbox_arb_state_t  w_state_nxt;
    logic [WB_DW-1:0] r_buf;
    logic [CW-1:0]    r_cnt;
    logic             r_lock;
    logic [NREQ-1:0]  r_grant;
    logic [IW-1:0]    r_owner;
    logic [IW-1:0]    r_ptr;

    logic [NREQ-1:0]  w_pick_oh;
    logic [IW-1:0]    w_pick_idx;
    logic             w_pick_vld;
    logic [NREQ-1:0]  w_sel_oh;
    logic [IW-1:0]    w_sel_idx;
    logic [WB_DW-1:0] w_sel_dat;
    logic             w_start;
    logic             w_write;
    logic             w_last;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .i_req    (req_i),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_vld)
    );

    // While locked only the current owner may continue; everyone else waits.
    assign w_sel_oh  = r_lock ? r_grant : w_pick_oh;
    assign w_sel_idx = r_lock ? r_owner : w_pick_idx;
    assign w_sel_dat = dat_i[w_sel_idx*WB_DW +: WB_DW];

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state <= MBOX_ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_write     = 1'b0;
        w_last      = 1'b0;
        unique case (r_state)
            MBOX_ARB_IDLE: begin
                w_start = r_lock ? req_i[r_owner] : w_pick_vld;
                if (w_start) begin
                    w_state_nxt = MBOX_ARB_SHIFT;
                end
            end
            MBOX_ARB_SHIFT: begin
                w_write = !mbox_full_i;
                w_last  = w_write && (r_cnt == LAST_CNT);
                if (w_last) begin
                    w_state_nxt = MBOX_ARB_IDLE;
                end
            end
            default: w_state_nxt = MBOX_ARB_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_buf   <= '0;
            r_cnt   <= '0;
            r_lock  <= 1'b0;
            r_grant <= '0;
            r_owner <= '0;
            r_ptr   <= IW'(NREQ - 1);
        end else if (r_state == MBOX_ARB_IDLE) begin
            if (w_start) begin
                r_buf   <= w_sel_dat;
                r_cnt   <= '0;
                r_grant <= w_sel_oh;
                r_owner <= w_sel_idx;
                r_ptr   <= w_sel_idx;
            end else if (!r_lock) begin
                r_grant <= '0;
            end
        end else if (w_write) begin
            r_buf <= r_buf >> WOU_DW;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_lock <= lock_i[r_owner];
            end
        end
    end

    assign grant_o   = r_grant;
    assign busy_o    = (r_state == MBOX_ARB_SHIFT);
    assign mbox_wr_o = w_write;
    assign mbox_do_o = busy_o ? r_buf[WOU_DW-1:0] : '0;
    assign ack_o     = w_last ? r_grant : '0;

endmodule

// File: tb/tb_mbox_wr_arbiter.sv
// tb/tb_mbox_wr_arbiter.sv - randomized and directed bench with a word-level arbitration reference model
module tb_mbox_wr_arbiter;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   lock;
    logic [NREQ*32-1:0] dat;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              wr;
    logic [7:0]        dout;
    logic              full;

    mbox_wr_arbiter #(.NREQ(NREQ), .WB_DW(32), .WOU_DW(8)) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .req_i       (req),
        .lock_i      (lock),
        .dat_i       (dat),
        .ack_o       (ack),
        .grant_o     (grant),
        .busy_o      (busy),
        .mbox_wr_o   (wr),
        .mbox_do_o   (dout),
        .mbox_full_i (full)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // requester agents
    int          rem[NREQ];
    bit          blk[NREQ];
    bit          rand_en;
    logic [NREQ-1:0] ack_q;

    // reference model: one word in flight, owner, byte index, lock carried to next idle cycle
    bit          m_prog;
    bit          m_lock;
    int          m_owner;
    int          m_last;
    int          m_idx;
    logic [31:0] m_word;
    logic [NREQ-1:0] m_grant;
    logic [NREQ-1:0] exp_ack;

    logic [7:0]  wlog[$];
    int          ord[$];
    int          ack_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] log_word();
        logic [31:0] v = '0;
        for (int i = 0; i < 4 && i < wlog.size(); i++) v[8*i +: 8] = wlog[i];
        return v;
    endfunction

    function automatic logic [31:0] pack_ord();
        logic [31:0] v = '0;
        foreach (ord[i]) v = (v << 4) | 32'(ord[i]);
        return v;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            m_prog = 0; m_lock = 0; m_owner = 0; m_last = NREQ - 1; m_idx = 0;
            m_grant = '0; ack_q = '0;
            check("rst_grant", 32'(grant), 32'h0);
            check("rst_ack", 32'(ack), 32'h0);
            check("rst_wr", 32'(wr), 32'h0);
            check("rst_busy", 32'(busy), 32'h0);
            check("rst_dout", 32'(dout), 32'h0);
        end else begin
            exp_ack = '0;
            check("grant", 32'(grant), 32'(m_grant));
            check("busy", 32'(busy), 32'(m_prog));
            if (m_prog) begin
                check("wr", 32'(wr), 32'(!full));
                if (!full) begin
                    check("byte", 32'(dout), 32'(m_word[8*m_idx +: 8]));
                    m_idx++;
                    if (m_idx == 4) begin
                        exp_ack = NREQ'(1) << m_owner;
                        m_lock = lock[m_owner];
                        m_prog = 0;
                    end
                end
            end else begin
                check("idle_wr", 32'(wr), 32'h0);
                if (m_lock) begin
                    if (req[m_owner]) m_prog = 1;
                end else begin
                    for (int i = 1; i <= NREQ; i++) begin
                        if (!m_prog && req[(m_last + i) % NREQ]) begin
                            m_prog = 1;
                            m_owner = (m_last + i) % NREQ;
                        end
                    end
                    if (!m_prog) m_grant = '0;
                end
                if (m_prog) begin
                    m_last = m_owner;
                    m_idx = 0;
                    m_word = dat[32*m_owner +: 32];
                    m_grant = NREQ'(1) << m_owner;
                end
            end
            check("ack", 32'(ack), 32'(exp_ack));
            if (wr) wlog.push_back(dout);
            for (int k = 0; k < NREQ; k++) begin
                if (ack[k]) begin
                    ord.push_back(k);
                    ack_cyc = cyc;
                end
            end
            ack_q = ack;
        end
    end

    task automatic start_burst(input int k, input int n, input logic [31:0] w, input bit lk);
        rem[k] = n;
        blk[k] = lk;
        dat[32*k +: 32] = w;
        req[k] = 1'b1;
        lock[k] = lk && (n > 1);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        for (int k = 0; k < NREQ; k++) begin
            if (ack_q[k]) begin
                rem[k]--;
                if (rem[k] > 0) begin
                    dat[32*k +: 32] = $urandom;
                    lock[k] = blk[k] && (rem[k] > 1);
                end else begin
                    req[k] = 1'b0;
                    lock[k] = 1'b0;
                end
            end else if (rand_en && rem[k] == 0 && $urandom_range(0, 3) == 0) begin
                start_burst(k, $urandom_range(1, 3), $urandom, 1'($urandom_range(0, 1)));
            end
        end
        if (rand_en) full = ($urandom_range(0, 3) == 0);
    endtask

    task automatic clear_agents();
        req = '0; lock = '0; full = 1'b0; rand_en = 0;
        for (int k = 0; k < NREQ; k++) begin
            rem[k] = 0;
            blk[k] = 0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_agents();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wlog.delete();
        ord.delete();
    endtask

    task automatic wait_acks(input string tag, input int n, input int budget);
        int start = ord.size();
        int c = 0;
        while (ord.size() - start < n && c < budget) begin
            cycle();
            c++;
        end
        check(tag, 32'(ord.size() - start), 32'(n));
    endtask

    int t0;
    int sum;

    initial begin
        dat = '0;
        ack_q = '0;
        do_reset();

        // T1 single word
        start_burst(0, 1, 32'h44332211, 0);
        t0 = cyc;
        wait_acks("t1_timeout", 1, 20);
        check("t1_bytes", log_word(), 32'h44332211);
        check("t1_nbytes", 32'(wlog.size()), 32'd4);
        check("t1_latency", 32'(ack_cyc - t0), 32'd4);

        // T2 contention
        do_reset();
        start_burst(0, 2, 32'h0A0B0C0D, 0);
        start_burst(1, 1, 32'h11121314, 0);
        start_burst(2, 1, 32'h21222324, 0);
        start_burst(3, 1, 32'h31323334, 0);
        wait_acks("t2_timeout", 5, 60);
        check("t2_order", pack_ord(), 32'h00001230);
        check("t2_nbytes", 32'(wlog.size()), 32'd20);

        // T3 backpressure after the 2nd byte
        do_reset();
        start_burst(0, 1, 32'hAABBCCDD, 0);
        t0 = cyc;
        repeat (3) cycle();
        full = 1'b1;
        repeat (3) cycle();
        full = 1'b0;
        wait_acks("t3_timeout", 1, 20);
        check("t3_bytes", log_word(), 32'hAABBCCDD);
        check("t3_nbytes", 32'(wlog.size()), 32'd4);
        check("t3_latency", 32'(ack_cyc - t0), 32'd7);

        // T4 locked burst from requester 1 with requester 2 pending
        do_reset();
        start_burst(1, 3, $urandom, 1);
        start_burst(2, 1, $urandom, 0);
        wait_acks("t4_timeout", 4, 60);
        check("t4_order", pack_ord(), 32'h00001112);

        // T5 reset mid-word
        do_reset();
        start_burst(1, 1, 32'h55667788, 0);
        repeat (3) cycle();
        check("t5_partial", 32'(wlog.size()), 32'd2);
        rst_n = 1'b0;
        #1;
        check("t5_grant", 32'(grant), 32'h0);
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_wr", 32'(wr), 32'h0);
        check("t5_ack", 32'(ack), 32'h0);
        clear_agents();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ord.delete();
        start_burst(3, 1, $urandom, 0);
        start_burst(0, 1, $urandom, 0);
        wait_acks("t5_timeout", 2, 40);
        check("t5_order", pack_ord(), 32'h00000003);

        // T6 full exactly on the last byte
        do_reset();
        start_burst(2, 1, 32'hAABBCCDD, 0);
        t0 = cyc;
        repeat (4) cycle();
        full = 1'b1;
        repeat (2) cycle();
        full = 1'b0;
        wait_acks("t6_timeout", 1, 20);
        check("t6_bytes", log_word(), 32'hAABBCCDD);
        check("t6_latency", 32'(ack_cyc - t0), 32'd6);

        // randomized traffic with locks and backpressure, then drain
        do_reset();
        rand_en = 1;
        repeat (3000) cycle();
        rand_en = 0;
        full = 1'b0;
        sum = 1;
        for (int c = 0; c < 400 && sum != 0; c++) begin
            cycle();
            sum = 0;
            for (int k = 0; k < NREQ; k++) sum += rem[k];
        end
        check("drain", 32'(sum), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
